// File: rtl/gru_seq_scheduler.sv
// gru_seq_scheduler: steps a GRU cell through a sequence, ping-ponging hidden-state banks per timestep
module gru_seq_scheduler #(
  parameter int T_W = 8,
  parameter int TIMEOUT = 40000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           seq_start,
  input  logic [T_W-1:0] seq_len,
  input  logic           h0_zero,
  input  logic           abort,
  output logic           x_rd_en,
  output logic [T_W-1:0] x_rd_addr,
  input  logic           x_rd_valid,
  output logic           h_clr,
  output logic           h_rd_bank,
  output logic           h_wr_en,
  output logic           cell_start,
  input  logic           cell_done,
  output logic           busy,
  output logic [T_W-1:0] step,
  output logic           seq_done,
  output logic           err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT_X, START, WAIT_CELL, WB, DONE} state_t;
  state_t state, state_d;
  logic [T_W-1:0] len, len_d, step_d, x_rd_addr_d;
  logic [CW-1:0] cnt, cnt_d;
  logic accept, zero_req, last, time_up, bank_d, err_d;
  logic x_rd_en_d, h_clr_d, h_wr_en_d, cell_start_d, seq_done_d;
  assign accept = state == IDLE && seq_start && seq_len != '0;
  assign zero_req = state == IDLE && seq_start && seq_len == '0 && !seq_done;
  assign last = step == len - T_W'(1);
  assign time_up = cnt == CW'(TIMEOUT - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      len <= '0;
      step <= '0;
      cnt <= '0;
      x_rd_addr <= '0;
      h_rd_bank <= 1'b0;
      err <= 1'b0;
      x_rd_en <= 1'b0;
      h_clr <= 1'b0;
      h_wr_en <= 1'b0;
      cell_start <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      state <= state_d;
      len <= len_d;
      step <= step_d;
      cnt <= cnt_d;
      x_rd_addr <= x_rd_addr_d;
      h_rd_bank <= bank_d;
      err <= err_d;
      x_rd_en <= x_rd_en_d;
      h_clr <= h_clr_d;
      h_wr_en <= h_wr_en_d;
      cell_start <= cell_start_d;
      seq_done <= seq_done_d;
    end
  always_comb begin
    state_d = state;
    if (abort && state != IDLE) state_d = IDLE;
    else
      case (state)
        IDLE:      if (accept) state_d = h0_zero ? CLEAR : FETCH;
        CLEAR:     state_d = FETCH;
        FETCH:     state_d = WAIT_X;
        WAIT_X:    if (x_rd_valid) state_d = START;
        START:     state_d = WAIT_CELL;
        WAIT_CELL: state_d = cell_done ? WB : time_up ? DONE : WAIT_CELL;
        WB:        state_d = last ? DONE : FETCH;
        DONE:      state_d = IDLE;
        default:   state_d = IDLE;
      endcase
  end
  always_comb begin
    len_d = accept ? seq_len : len;
    step_d = accept ? '0 : (state == WB && state_d == FETCH) ? step + T_W'(1) : step;
    bank_d = accept ? 1'b0 : (state == WB && state_d != IDLE) ? ~h_rd_bank : h_rd_bank;
    err_d = accept ? 1'b0 : (zero_req || (state == WAIT_CELL && state_d == DONE)) ? 1'b1 : err;
    cnt_d = state == WAIT_CELL ? cnt + CW'(1) : '0;
    x_rd_addr_d = state_d == FETCH ? step_d : x_rd_addr;
    x_rd_en_d = state_d == FETCH;
    h_clr_d = state_d == CLEAR;
    cell_start_d = state_d == START;
    h_wr_en_d = state_d == WB;
    seq_done_d = state_d == DONE || zero_req;
  end
endmodule

// File: tb/tb_gru_seq_scheduler.sv
// tb_gru_seq_scheduler: randomized self-checking bench for gru_seq_scheduler against a timing model
module tb_gru_seq_scheduler;
  localparam int T_W = 8;
  localparam int TO = 16;
  logic clk = 0, rst = 0, seq_start = 0, h0_zero = 0, abort = 0, x_rd_valid = 0, cell_done = 0;
  logic [T_W-1:0] seq_len = '0;
  logic x_rd_en, h_clr, h_rd_bank, h_wr_en, cell_start, busy, seq_done, err;
  logic [T_W-1:0] x_rd_addr, step;
  int n_tests = 0, n_fail = 0;
  int bl = 1, cl = 5, xc = 0, cc = 0;
  bit cen = 1;

  gru_seq_scheduler #(.T_W(T_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .seq_start(seq_start), .seq_len(seq_len), .h0_zero(h0_zero),
    .abort(abort), .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_valid(x_rd_valid),
    .h_clr(h_clr), .h_rd_bank(h_rd_bank), .h_wr_en(h_wr_en), .cell_start(cell_start),
    .cell_done(cell_done), .busy(busy), .step(step), .seq_done(seq_done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      x_rd_valid = xc == 1;
      cell_done = cc == 1;
      if (xc > 0) xc--;
      if (cc > 0) cc--;
      if (x_rd_en) xc = bl;
      if (cell_start && cen) cc = cl;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic run_seq(input int n, input bit h0, input bit noise, input int budget,
      output int done_at, output int n_cs, output int n_wr, output int clr_at,
      output int n_x, output int bad_addr, output bit dbl);
    logic [4:0] prev, cur;
    prev = '0; done_at = -1; n_cs = 0; n_wr = 0; clr_at = -1; n_x = 0; bad_addr = 0; dbl = 0;
    @(negedge clk);
    seq_start = 1; seq_len = T_W'(n); h0_zero = h0;
    for (int r = 1; r <= budget && done_at < 0; r++) begin
      @(negedge clk);
      seq_start = 0;
      cur = {x_rd_en, h_clr, h_wr_en, cell_start, seq_done};
      if ((cur & prev) != '0) dbl = 1;
      prev = cur;
      if (x_rd_en) begin
        if (int'(x_rd_addr) != n_x) bad_addr++;
        n_x++;
      end
      if (h_clr && clr_at < 0) clr_at = r;
      n_cs += int'(cell_start);
      n_wr += int'(h_wr_en);
      if (seq_done) done_at = r;
      else if (noise && busy && $urandom_range(0, 3) == 0) begin
        seq_start = 1;
        seq_len = T_W'($urandom_range(0, 255));
      end
    end
    seq_start = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    @(negedge clk); @(negedge clk);
    n_tests++; if ({x_rd_en, h_clr, h_wr_en, cell_start, seq_done} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes got %b want 00000", {x_rd_en, h_clr, h_wr_en, cell_start, seq_done}); end
    n_tests++; if ({busy, h_rd_bank, err} !== 3'b0) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, h_rd_bank, err}); end
    n_tests++; if (step !== '0 || x_rd_addr !== '0) begin n_fail++; $display("FAIL reset_step got %0d/%0d want 0/0", step, x_rd_addr); end
    rst = 0;
  endtask

  task automatic test_basic;
    int d, cs, wr, ca, nx, ba; bit db;
    bl = 1; cl = 5; cen = 1;
    run_seq(3, 0, 0, 200, d, cs, wr, ca, nx, ba, db);
    n_tests++; if (d != 28) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 28", d); end
    n_tests++; if (cs != 3 || wr != 3) begin n_fail++; $display("FAIL basic_counts got cs=%0d wr=%0d want 3/3", cs, wr); end
    n_tests++; if (nx != 3 || ba != 0) begin n_fail++; $display("FAIL basic_fetch got n=%0d bad=%0d want 3/0", nx, ba); end
    n_tests++; if (h_rd_bank !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL basic_bank_err got %b%b want 10", h_rd_bank, err); end
    n_tests++; if (int'(step) != 2 || ca != -1 || db) begin n_fail++; $display("FAIL basic_misc got step=%0d clr=%0d dbl=%0d want 2/-1/0", step, ca, db); end
  endtask

  task automatic test_h0;
    int d, cs, wr, ca, nx, ba; bit db;
    bl = 1; cl = 1; cen = 1;
    run_seq(1, 1, 0, 100, d, cs, wr, ca, nx, ba, db);
    n_tests++; if (ca != 1) begin n_fail++; $display("FAIL h0_clr_cycle got %0d want 1", ca); end
    n_tests++; if (d != 7) begin n_fail++; $display("FAIL h0_done_cycle got %0d want 7", d); end
    n_tests++; if (h_rd_bank !== 1'b1 || wr != 1) begin n_fail++; $display("FAIL h0_bank got bank=%b wr=%0d want 1/1", h_rd_bank, wr); end
  endtask

  task automatic test_zero_len;
    int d, cs, wr, ca, nx, ba; bit db;
    bl = 1; cl = 5; cen = 1;
    run_seq(0, 0, 0, 20, d, cs, wr, ca, nx, ba, db);
    n_tests++; if (d != 1 || cs != 0 || nx != 0) begin n_fail++; $display("FAIL zero_len got done=%0d cs=%0d x=%0d want 1/0/0", d, cs, nx); end
    n_tests++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_len_err got err=%b busy=%b want 1/0", err, busy); end
    run_seq(2, 0, 0, 100, d, cs, wr, ca, nx, ba, db);
    n_tests++; if (err !== 1'b0 || d != 19) begin n_fail++; $display("FAIL zero_len_clear got err=%b done=%0d want 0/19", err, d); end
  endtask

  task automatic test_timeout;
    int d, cs, wr, ca, nx, ba; bit db;
    bl = 1; cen = 0;
    run_seq(2, 0, 0, 100, d, cs, wr, ca, nx, ba, db);
    n_tests++; if (d != 20 || err !== 1'b1) begin n_fail++; $display("FAIL timeout got done=%0d err=%b want 20/1", d, err); end
    n_tests++; if (wr != 0 || cs != 1 || step !== '0 || h_rd_bank !== 1'b0) begin n_fail++; $display("FAIL timeout_hold got wr=%0d cs=%0d step=%0d bank=%b want 0/1/0/0", wr, cs, step, h_rd_bank); end
    cen = 1; cl = 16;
    run_seq(1, 0, 0, 100, d, cs, wr, ca, nx, ba, db);
    n_tests++; if (d != 21 || err !== 1'b0 || wr != 1) begin n_fail++; $display("FAIL timeout_edge_done got done=%0d err=%b wr=%0d want 21/0/1", d, err, wr); end
    cl = 17;
    run_seq(1, 0, 0, 100, d, cs, wr, ca, nx, ba, db);
    n_tests++; if (d != 20 || err !== 1'b1 || wr != 0) begin n_fail++; $display("FAIL timeout_edge_late got done=%0d err=%b wr=%0d want 20/1/0", d, err, wr); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort;
    int d, cs, wr, ca, nx, ba, wr_after, dn, step_a; bit db; logic busy_a, bank_a;
    bl = 1; cl = 8; cen = 1; wr_after = 0; dn = 0; step_a = -1; busy_a = 1'bx; bank_a = 1'bx;
    @(negedge clk);
    seq_start = 1; seq_len = 4; h0_zero = 0;
    for (int r = 1; r <= 50; r++) begin
      @(negedge clk);
      seq_start = 0; abort = 0;
      if (r == 31) begin busy_a = busy; step_a = int'(step); bank_a = h_rd_bank; end
      if (r >= 31) begin wr_after += int'(h_wr_en); dn += int'(seq_done); end
      if (r == 30) abort = 1;
    end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_idle got busy=%b want 0", busy_a); end
    n_tests++; if (step_a != 2 || bank_a !== 1'b0) begin n_fail++; $display("FAIL abort_hold got step=%0d bank=%b want 2/0", step_a, bank_a); end
    n_tests++; if (wr_after != 0 || dn != 0 || err !== 1'b0) begin n_fail++; $display("FAIL abort_quiet got wr=%0d done=%0d err=%b want 0/0/0", wr_after, dn, err); end
    cl = 5;
    run_seq(2, 0, 0, 100, d, cs, wr, ca, nx, ba, db);
    n_tests++; if (d != 19 || wr != 2 || ba != 0) begin n_fail++; $display("FAIL abort_rerun got done=%0d wr=%0d bad=%0d want 19/2/0", d, wr, ba); end
  endtask

  task automatic test_abort_collide;
    int wr_all; logic [3:0] snap;
    bl = 1; cl = 5; cen = 1; wr_all = 0; snap = 'x;
    @(negedge clk);
    seq_start = 1; seq_len = 2; h0_zero = 0;
    for (int r = 1; r <= 15; r++) begin
      @(negedge clk);
      seq_start = 0; abort = 0;
      wr_all += int'(h_wr_en);
      if (r == 9) snap = {h_wr_en, busy, step[0], h_rd_bank};
      if (r == 8) abort = 1;
    end
    n_tests++; if (snap !== 4'b0000) begin n_fail++; $display("FAIL abort_collide got wr/busy/step/bank=%b want 0000", snap); end
    n_tests++; if (wr_all != 0 || seq_done !== 1'b0) begin n_fail++; $display("FAIL abort_collide_wr got wr=%0d want 0", wr_all); end
  endtask

  task automatic test_reset_mid;
    int dr;
    bl = 3; cl = 5; cen = 1; dr = -1;
    @(negedge clk);
    seq_start = 1; seq_len = 3; h0_zero = 0;
    for (int r = 1; r <= 14; r++) begin
      @(negedge clk);
      seq_start = r == 13;
      if (r == 13) seq_len = 9;
    end
    seq_start = 0;
    n_tests++; if (busy !== 1'b1 || int'(step) != 1 || int'(x_rd_addr) != 1 || h_rd_bank !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got busy=%b step=%0d addr=%0d bank=%b want 1/1/1/1", busy, step, x_rd_addr, h_rd_bank); end
    #2 rst = 1;
    #1;
    n_tests++; if ({busy, h_rd_bank, err, x_rd_en, h_clr, h_wr_en, cell_start, seq_done} !== 8'b0) begin n_fail++; $display("FAIL rstmid_async_flags got %b want 00000000", {busy, h_rd_bank, err, x_rd_en, h_clr, h_wr_en, cell_start, seq_done}); end
    n_tests++; if (step !== '0 || x_rd_addr !== '0) begin n_fail++; $display("FAIL rstmid_async_step got %0d/%0d want 0/0", step, x_rd_addr); end
    repeat (10) @(negedge clk);
    bl = 1;
    rst = 0; seq_start = 1; seq_len = 1; h0_zero = 0;
    @(negedge clk);
    seq_start = 0;
    n_tests++; if (x_rd_en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_first_edge got x_rd_en=%b busy=%b want 1/1", x_rd_en, busy); end
    for (int r = 2; r <= 40 && dr < 0; r++) begin
      @(negedge clk);
      if (seq_done) dr = r;
    end
    n_tests++; if (dr != 10) begin n_fail++; $display("FAIL rstmid_rerun got done=%0d want 10", dr); end
  endtask

  task automatic test_random;
    int d, cs, wr, ca, nx, ba, n, e_d, e_cs, e_wr, e_x, e_step; bit db, h0, e_err, e_bank;
    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(1, 6); h0 = 1'($urandom_range(0, 1));
      bl = $urandom_range(1, 3); cl = $urandom_range(1, 18); cen = 1;
      if (cl <= TO) begin
        e_d = 1 + int'(h0) + n * (cl + bl + 3); e_cs = n; e_wr = n; e_x = n;
        e_err = 0; e_bank = 1'(n % 2); e_step = n - 1;
      end else begin
        e_d = int'(h0) + bl + 19; e_cs = 1; e_wr = 0; e_x = 1;
        e_err = 1; e_bank = 0; e_step = 0;
      end
      run_seq(n, h0, 1, 400, d, cs, wr, ca, nx, ba, db);
      n_tests++; if (d != e_d) begin n_fail++; $display("FAIL rnd%0d_done got %0d want %0d (n=%0d h0=%0d bl=%0d cl=%0d)", i, d, e_d, n, h0, bl, cl); end
      n_tests++; if (cs != e_cs || wr != e_wr) begin n_fail++; $display("FAIL rnd%0d_counts got cs=%0d wr=%0d want %0d/%0d", i, cs, wr, e_cs, e_wr); end
      n_tests++; if (nx != e_x || ba != 0) begin n_fail++; $display("FAIL rnd%0d_fetch got n=%0d bad=%0d want %0d/0", i, nx, ba, e_x); end
      n_tests++; if (err !== e_err || h_rd_bank !== e_bank) begin n_fail++; $display("FAIL rnd%0d_err_bank got %b%b want %b%b", i, err, h_rd_bank, e_err, e_bank); end
      n_tests++; if (int'(step) != e_step) begin n_fail++; $display("FAIL rnd%0d_step got %0d want %0d", i, step, e_step); end
      n_tests++; if (ca != (h0 ? 1 : -1) || db) begin n_fail++; $display("FAIL rnd%0d_clr_dbl got clr=%0d dbl=%0d want %0d/0", i, ca, db, h0 ? 1 : -1); end
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_h0;
    test_zero_len;
    test_timeout;
    test_abort;
    test_abort_collide;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
